// File: rtl/mem_stage_if.sv
// Request/ready data-memory bus between the MEM stage (master) and data memory (slave).
// The master drives the request, the direction, the word address and the store data. The slave returns read data and a ready strobe.
interface mem_stage_if;
    logic        bus_req;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy;

    modport master (
        output bus_req, bus_rw, bus_addr, bus_wr_data,
        input  bus_rd_data, bus_rdy
    );

    modport slave (
        input  bus_req, bus_rw, bus_addr, bus_wr_data,
        output bus_rd_data, bus_rdy
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: performs word loads and stores over a request/ready bus and stalls upstream while an access is outstanding.
// It registers the MEM/WB values and an exception code for misaligned or timed-out accesses.
module mem_stage #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ex_out,
    input  logic [4:0]       ex_dst_address,
    input  logic             ex_gpr_we_,
    input  logic [1:0]       ex_mem_op,
    input  logic [31:0]      ex_mem_wr_data,
    input  logic             flush,
    mem_stage_if.master      bus,
    output logic             mem_busy,
    output logic [31:0]      mem_out,
    output logic [4:0]       mem_dst_address,
    output logic             mem_gpr_we_,
    output logic [1:0]       mem_exp_code
);

    localparam logic [1:0] OP_LOAD     = 2'b01;
    localparam logic [1:0] OP_STORE    = 2'b10;
    localparam logic [1:0] EXP_NONE    = 2'b00;
    localparam logic [1:0] EXP_MISALGN = 2'b01;
    localparam logic [1:0] EXP_TIMEOUT = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        pending_flush_q, pending_flush_d;
    logic [31:0] mem_out_q, mem_out_d;
    logic [4:0]  mem_dst_address_q, mem_dst_address_d;
    logic        mem_gpr_we_q, mem_gpr_we_d;
    logic [1:0]  mem_exp_code_q, mem_exp_code_d;

    logic        is_mem;
    logic        aligned;
    logic        valid_access;
    logic        is_load;
    logic [31:0] res_out;
    logic        res_we;
    logic        kill;

    assign is_load      = (ex_mem_op == OP_LOAD);
    assign is_mem       = is_load || (ex_mem_op == OP_STORE);
    assign aligned      = (ex_out[1:0] == 2'b00);
    assign valid_access = is_mem && aligned && !flush;

    // While reset is asserted the request must drop at once, even if the ex_* inputs hold a valid access.
    assign bus.bus_req     = !rst && ((state_q == BUSY) || valid_access);
    assign bus.bus_rw      = (ex_mem_op != OP_STORE);
    assign bus.bus_addr    = ex_out[31:2];
    assign bus.bus_wr_data = ex_mem_wr_data;
    assign mem_busy        = bus.bus_req && !bus.bus_rdy;

    // On completion, a load returns bus data and its own write enable. A store never writes a GPR.
    assign res_out = is_load ? bus.bus_rd_data : ex_out;
    assign res_we  = is_load ? ex_gpr_we_ : 1'b1;

    assign mem_out         = mem_out_q;
    assign mem_dst_address = mem_dst_address_q;
    assign mem_gpr_we_     = mem_gpr_we_q;
    assign mem_exp_code    = mem_exp_code_q;

    always_comb begin
        state_d           = state_q;
        tmo_cnt_d         = tmo_cnt_q;
        pending_flush_d   = pending_flush_q;
        mem_out_d         = 32'd0;
        mem_dst_address_d = 5'd0;
        mem_gpr_we_d      = 1'b1;
        mem_exp_code_d    = EXP_NONE;
        kill              = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    kill = 1'b1;
                end else if (is_mem && !aligned) begin
                    mem_out_d         = ex_out;
                    mem_dst_address_d = ex_dst_address;
                    mem_exp_code_d    = EXP_MISALGN;
                end else if (is_mem) begin
                    if (bus.bus_rdy) begin
                        mem_out_d         = res_out;
                        mem_dst_address_d = ex_dst_address;
                        mem_gpr_we_d      = res_we;
                    end else begin
                        state_d         = BUSY;
                        tmo_cnt_d       = 8'd1;
                        pending_flush_d = 1'b0;
                    end
                end else begin
                    mem_out_d         = ex_out;
                    mem_dst_address_d = ex_dst_address;
                    mem_gpr_we_d      = ex_gpr_we_;
                end
            end
            BUSY: begin
                kill = pending_flush_q || flush;
                // A ready strobe takes priority over a timeout that expires in the same cycle.
                if (bus.bus_rdy) begin
                    state_d         = IDLE;
                    pending_flush_d = 1'b0;
                    if (!kill) begin
                        mem_out_d         = res_out;
                        mem_dst_address_d = ex_dst_address;
                        mem_gpr_we_d      = res_we;
                    end
                end else if (tmo_cnt_q == TIMEOUT) begin
                    state_d         = IDLE;
                    pending_flush_d = 1'b0;
                    if (!kill) begin
                        mem_out_d         = ex_out;
                        mem_dst_address_d = ex_dst_address;
                        mem_exp_code_d    = EXP_TIMEOUT;
                    end
                end else begin
                    tmo_cnt_d       = tmo_cnt_q + 8'd1;
                    pending_flush_d = kill;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            tmo_cnt_q         <= 8'd0;
            pending_flush_q   <= 1'b0;
            mem_out_q         <= 32'd0;
            mem_dst_address_q <= 5'd0;
            mem_gpr_we_q      <= 1'b1;
            mem_exp_code_q    <= EXP_NONE;
        end else begin
            state_q           <= state_d;
            tmo_cnt_q         <= tmo_cnt_d;
            pending_flush_q   <= pending_flush_d;
            mem_out_q         <= mem_out_d;
            mem_dst_address_q <= mem_dst_address_d;
            mem_gpr_we_q      <= mem_gpr_we_d;
            mem_exp_code_q    <= mem_exp_code_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then a randomized run.
// A behavioural model tracks the outstanding access and is compared against the DUT every cycle.
module tb_mem_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ex_out = '0;
    logic [4:0]  ex_dst_address = '0;
    logic        ex_gpr_we_ = 1'b1;
    logic [1:0]  ex_mem_op = '0;
    logic [31:0] ex_mem_wr_data = '0;
    logic        flush = 1'b0;
    logic        mem_busy;
    logic [31:0] mem_out;
    logic [4:0]  mem_dst_address;
    logic        mem_gpr_we_;
    logic [1:0]  mem_exp_code;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_if bus_if ();

    mem_stage #(.TIMEOUT(8'(TMO))) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_out          (ex_out),
        .ex_dst_address  (ex_dst_address),
        .ex_gpr_we_      (ex_gpr_we_),
        .ex_mem_op       (ex_mem_op),
        .ex_mem_wr_data  (ex_mem_wr_data),
        .flush           (flush),
        .bus             (bus_if),
        .mem_busy        (mem_busy),
        .mem_out         (mem_out),
        .mem_dst_address (mem_dst_address),
        .mem_gpr_we_     (mem_gpr_we_),
        .mem_exp_code    (mem_exp_code)
    );

    always #5 clk = ~clk;

    initial begin
        bus_if.bus_rdy     = 1'b0;
        bus_if.bus_rd_data = '0;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an access is either absent or outstanding for some number of cycles.
    bit          m_out_standing = 1'b0;
    int          m_waited       = 0;
    bit          m_flushed      = 1'b0;
    logic [31:0] e_out = '0;
    logic [4:0]  e_dst = '0;
    logic        e_we  = 1'b1;
    logic [1:0]  e_exp = '0;
    bit          e_dst_chk = 1'b1;

    task automatic m_set(input logic [31:0] o, input logic [4:0] d, input logic w, input logic [1:0] x, input bit dchk);
        e_out = o; e_dst = d; e_we = w; e_exp = x; e_dst_chk = dchk;
    endtask

    task automatic m_complete();
        if (ex_mem_op == 2'b01) m_set(bus_if.bus_rd_data, ex_dst_address, ex_gpr_we_, 2'b00, 1'b1);
        else                    m_set(ex_out, 5'd0, 1'b1, 2'b00, 1'b0);
    endtask

    always @(posedge clk or posedge rst) begin
        bit acc, mis;
        if (rst) begin
            m_out_standing = 1'b0;
            m_waited       = 0;
            m_flushed      = 1'b0;
            m_set(32'd0, 5'd0, 1'b1, 2'b00, 1'b1);
        end else begin
            acc = (ex_mem_op == 2'b01) || (ex_mem_op == 2'b10);
            mis = acc && (ex_out[1:0] != 2'b00);
            m_set(32'd0, 5'd0, 1'b1, 2'b00, 1'b1);
            if (!m_out_standing) begin
                if (flush) begin
                end else if (mis) begin
                    m_set(ex_out, 5'd0, 1'b1, 2'b01, 1'b0);
                end else if (acc) begin
                    if (bus_if.bus_rdy) m_complete();
                    else begin
                        m_out_standing = 1'b1;
                        m_waited = 1;
                        m_flushed = 1'b0;
                    end
                end else begin
                    m_set(ex_out, ex_dst_address, ex_gpr_we_, 2'b00, 1'b1);
                end
            end else begin
                m_flushed = m_flushed || flush;
                if (bus_if.bus_rdy) begin
                    if (!m_flushed) m_complete();
                    m_out_standing = 1'b0;
                end else if (m_waited >= TMO) begin
                    if (!m_flushed) m_set(ex_out, 5'd0, 1'b1, 2'b10, 1'b0);
                    m_out_standing = 1'b0;
                end else begin
                    m_waited++;
                end
            end
        end
    end

    bit chk_en = 1'b1;
    bit exp_busy_last = 1'b0;

    always @(negedge clk) begin
        bit acc, x_req, x_busy;
        if (chk_en) begin
            acc    = ((ex_mem_op == 2'b01) || (ex_mem_op == 2'b10)) && (ex_out[1:0] == 2'b00);
            x_req  = !rst && (m_out_standing || (acc && !flush));
            x_busy = x_req && !bus_if.bus_rdy;
            exp_busy_last = x_busy;
            cmp("bus_req", 32'(bus_if.bus_req), 32'(x_req));
            cmp("mem_busy", 32'(mem_busy), 32'(x_busy));
            if (x_req) cmp("bus_rw", 32'(bus_if.bus_rw), 32'(ex_mem_op == 2'b01));
            cmp("bus_addr", 32'(bus_if.bus_addr), {2'b00, ex_out[31:2]});
            cmp("bus_wr_data", bus_if.bus_wr_data, ex_mem_wr_data);
            cmp("mem_out", mem_out, e_out);
            cmp("mem_gpr_we_", 32'(mem_gpr_we_), 32'(e_we));
            cmp("mem_exp_code", 32'(mem_exp_code), 32'(e_exp));
            if (e_dst_chk) cmp("mem_dst_address", 32'(mem_dst_address), 32'(e_dst));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] d, input logic we_);
        ex_mem_op = op; ex_out = a; ex_mem_wr_data = wd; ex_dst_address = d; ex_gpr_we_ = we_;
    endtask

    task automatic nop_settle();
        set_ex(2'b00, 32'h0000_0100, 32'd0, 5'd1, 1'b1);
        flush = 1'b0;
        bus_if.bus_rdy = 1'b0;
        tick();
    endtask

    initial begin
        set_ex(2'b01, 32'h0000_0010, 32'd0, 5'd2, 1'b0);
        tick();
        #2;
        cmp("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        cmp("rst_mem_busy", 32'(mem_busy), 32'd0);
        cmp("rst_mem_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        cmp("rst_mem_out", mem_out, 32'd0);
        tick();
        set_ex(2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
        rst = 1'b0;
        tick();

        // Zero-wait-state load.
        set_ex(2'b01, 32'h0000_0010, 32'd0, 5'd5, 1'b0);
        bus_if.bus_rdy = 1'b1;
        bus_if.bus_rd_data = 32'hDEAD_BEEF;
        #2;
        cmp("t1_bus_addr", 32'(bus_if.bus_addr), 32'h4);
        cmp("t1_bus_rw", 32'(bus_if.bus_rw), 32'd1);
        cmp("t1_mem_busy", 32'(mem_busy), 32'd0);
        tick();
        cmp("t1_mem_out", mem_out, 32'hDEAD_BEEF);
        cmp("t1_mem_gpr_we_", 32'(mem_gpr_we_), 32'd0);
        cmp("t1_mem_dst", 32'(mem_dst_address), 32'd5);
        cmp("t1_exp", 32'(mem_exp_code), 32'd0);
        nop_settle();

        // Store that completes after three wait cycles.
        set_ex(2'b10, 32'h0000_0020, 32'h1234_5678, 5'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            cmp("t2_bus_req", 32'(bus_if.bus_req), 32'd1);
            cmp("t2_bus_rw", 32'(bus_if.bus_rw), 32'd0);
            cmp("t2_mem_busy", 32'(mem_busy), 32'd1);
            tick();
            cmp("t2_bubble_we", 32'(mem_gpr_we_), 32'd1);
            cmp("t2_bubble_out", mem_out, 32'd0);
        end
        bus_if.bus_rdy = 1'b1;
        #2;
        cmp("t2_last_req", 32'(bus_if.bus_req), 32'd1);
        cmp("t2_last_busy", 32'(mem_busy), 32'd0);
        tick();
        cmp("t2_mem_out", mem_out, 32'h0000_0020);
        cmp("t2_mem_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        nop_settle();

        // Misaligned load.
        set_ex(2'b01, 32'h0000_0022, 32'd0, 5'd7, 1'b0);
        #2;
        cmp("t3_bus_req", 32'(bus_if.bus_req), 32'd0);
        cmp("t3_mem_busy", 32'(mem_busy), 32'd0);
        tick();
        cmp("t3_exp", 32'(mem_exp_code), 32'd1);
        cmp("t3_mem_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        cmp("t3_mem_out", mem_out, 32'h0000_0022);
        nop_settle();

        // Load that times out after TMO busy cycles.
        set_ex(2'b01, 32'h0000_0040, 32'd0, 5'd8, 1'b0);
        for (int i = 0; i < TMO + 1; i++) begin
            #2;
            cmp("t4_mem_busy", 32'(mem_busy), 32'd1);
            tick();
        end
        cmp("t4_exp", 32'(mem_exp_code), 32'd2);
        cmp("t4_mem_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        cmp("t4_mem_out", mem_out, 32'h0000_0040);
        set_ex(2'b00, 32'h0000_0055, 32'd0, 5'd7, 1'b0);
        #2;
        cmp("t4_bus_req_after", 32'(bus_if.bus_req), 32'd0);
        cmp("t4_busy_after", 32'(mem_busy), 32'd0);
        tick();
        cmp("t4_nop_out", mem_out, 32'h0000_0055);
        cmp("t4_nop_we", 32'(mem_gpr_we_), 32'd0);
        cmp("t4_nop_dst", 32'(mem_dst_address), 32'd7);
        cmp("t4_nop_exp", 32'(mem_exp_code), 32'd0);
        nop_settle();

        // Flush during a stalled load turns the completion into a bubble.
        set_ex(2'b01, 32'h0000_0080, 32'd0, 5'd9, 1'b0);
        bus_if.bus_rd_data = 32'hCAFE_0001;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus_if.bus_rdy = 1'b1;
        #2;
        cmp("t5_bus_req", 32'(bus_if.bus_req), 32'd1);
        cmp("t5_mem_busy", 32'(mem_busy), 32'd0);
        tick();
        cmp("t5_mem_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        cmp("t5_exp", 32'(mem_exp_code), 32'd0);
        cmp("t5_mem_out", mem_out, 32'd0);
        nop_settle();

        // Reset in the middle of a stalled access, then a fresh load.
        set_ex(2'b01, 32'h0000_00C0, 32'd0, 5'd3, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        cmp("t6_bus_req", 32'(bus_if.bus_req), 32'd0);
        cmp("t6_mem_busy", 32'(mem_busy), 32'd0);
        cmp("t6_mem_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        tick();
        rst = 1'b0;
        set_ex(2'b01, 32'h0000_0100, 32'd0, 5'd9, 1'b0);
        bus_if.bus_rdy = 1'b1;
        bus_if.bus_rd_data = 32'hA5A5_0001;
        #2;
        cmp("t6_fresh_req", 32'(bus_if.bus_req), 32'd1);
        cmp("t6_fresh_busy", 32'(mem_busy), 32'd0);
        tick();
        cmp("t6_fresh_out", mem_out, 32'hA5A5_0001);
        cmp("t6_fresh_we", 32'(mem_gpr_we_), 32'd0);
        cmp("t6_fresh_dst", 32'(mem_dst_address), 32'd9);
        nop_settle();

        // Randomized traffic; upstream holds its inputs while the stage stalls.
        for (int i = 0; i < 3000; i++) begin
            if (!exp_busy_last) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                set_ex(2'($urandom_range(0, 3)), a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
            flush = ($urandom_range(0, 7) == 0);
            bus_if.bus_rdy = (i < 1500) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
            bus_if.bus_rd_data = $urandom;
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. It consumes the EX/MEM register outputs (result, destination, write-enable, memory op, store data) and performs word loads and stores to data memory over a request/ready bus.
- It stalls the upstream pipeline while a bus access is outstanding.
- It registers the MEM/WB values consumed by write-back, plus an exception code for misaligned and timed-out accesses.

Parameters:
- TIMEOUT, default 8'd255: number of BUSY cycles without bus_rdy before the access is aborted with a bus-timeout exception.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ex_out  input  32  ALU result; the memory byte address for load/store
- ex_dst_address  input  5  destination GPR
- ex_gpr_we_  input  1  GPR write enable, active-low
- ex_mem_op  input  2  00 NOP, 01 LOAD word, 10 STORE word, 11 reserved (treated as NOP)
- ex_mem_wr_data  input  32  store data
- flush  input  1  squash the current instruction
- bus_req  output  1  bus request
- bus_rw  output  1  1 = read, 0 = write
- bus_addr  output  30  word address = ex_out[31:2]
- bus_wr_data  output  32  = ex_mem_wr_data
- bus_rd_data  input  32  load data, valid when bus_rdy=1
- bus_rdy  input  1  access complete this cycle
- mem_busy  output  1  stall request to IF/ID/EX (combinational)
- mem_out  output  32  value for write-back
- mem_dst_address  output  5  registered destination
- mem_gpr_we_  output  1  registered write enable, active-low
- mem_exp_code  output  2  00 none, 01 misaligned, 10 bus timeout

Behaviour:
- FSM has two states, IDLE and BUSY. Timeout counter tmo_cnt is 8 bits wide.
- An access is valid when ex_mem_op is LOAD or STORE, ex_out[1:0]==2'b00 and flush==0.
- bus_req is combinational:
  - In IDLE it equals the valid-access condition.
  - In BUSY it is held at 1.
- bus_rw, bus_addr and bus_wr_data are combinational from the ex_* inputs. Upstream holds the ex_* inputs stable while mem_busy=1.
- mem_busy = bus_req & ~bus_rdy.
- IDLE:
  - Valid access with bus_rdy=1: completes in zero wait states and the result is registered on this edge.
  - Valid access with bus_rdy=0: go to BUSY, tmo_cnt <= 1.
- BUSY:
  - bus_rdy=1: return to IDLE and register the result.
  - Otherwise, if tmo_cnt==TIMEOUT: abort. bus_req drops on the next cycle, state returns to IDLE, and the timeout result is registered.
  - Otherwise tmo_cnt increments.
- Output register update, on the clock edge when the stage is not stalled:
  - LOAD complete: mem_out=bus_rd_data, mem_dst_address=ex_dst_address, mem_gpr_we_=ex_gpr_we_, exp=00.
  - STORE complete: mem_out=ex_out, mem_gpr_we_=1, exp=00.
  - NOP/reserved: mem_out=ex_out, mem_dst_address=ex_dst_address, mem_gpr_we_=ex_gpr_we_, exp=00.
  - Misaligned LOAD/STORE: no bus request, no stall, mem_gpr_we_=1, mem_out=ex_out, exp=01.
  - Timeout: mem_gpr_we_=1, mem_out=ex_out, exp=10.
- While mem_busy=1, the output registers load a bubble every cycle: mem_out=0, mem_dst_address=0, mem_gpr_we_=1, exp=00. Write-back therefore never sees a duplicate write.
- Flush:
  - In IDLE, flush suppresses the request and the output registers load a bubble.
  - Flush asserted in BUSY does not abort the bus transaction. It is latched in pending_flush; on completion or timeout a bubble is registered instead of the result, and pending_flush clears.
- Reset (asynchronous):
  - state=IDLE, tmo_cnt=0, pending_flush=0.
  - mem_out=0, mem_dst_address=0, mem_gpr_we_=1, mem_exp_code=00.
  - bus_req=0 and mem_busy=0 immediately.
  - Reset during BUSY abandons the access with no bus cleanup.
- Simultaneous bus_rdy and timeout in the same cycle: bus_rdy wins and the access completes normally.

Test Plan:
1. LOAD, ex_out=0x0000_0010, bus_rdy=1 in the same cycle -> bus_addr=0x4, bus_rw=1, mem_busy=0; next edge mem_out=bus_rd_data (0xDEAD_BEEF), mem_gpr_we_=0, exp=00.
2. STORE, ex_out=0x20, ex_mem_wr_data=0x1234_5678, bus_rdy after 3 cycles -> bus_req=1, bus_rw=0 for 4 cycles; mem_busy=1 for 3 cycles with bubbles registered; then mem_gpr_we_=1, mem_out=0x20.
3. LOAD at ex_out=0x22 -> bus_req stays 0, mem_busy=0; next edge exp=01, mem_gpr_we_=1.
4. LOAD, TIMEOUT=4, bus_rdy never asserted -> mem_busy high for exactly 5 cycles (IDLE cycle + 4 BUSY), then exp=10, bus_req=0, state IDLE; a following NOP passes through unchanged.
5. LOAD stalled in BUSY, flush pulsed in the second BUSY cycle, bus_rdy in the third -> bus transaction completes; registered output is a bubble (mem_gpr_we_=1, exp=00).
6. rst asserted mid-BUSY -> bus_req, mem_busy and mem_gpr_we_ take reset values asynchronously; after release a fresh LOAD completes normally.
